// File: rtl/play_timer_pkg.sv
// Shared types and helpers for the play_timer elapsed-time counter.
// PLAY_TIMER_LOAD_EN enables the preset-load path that uses bcd_to_sec.
package play_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t DIGIT_MAX    = 4'd9;

  // mm:ss in BCD to binary seconds; x10 = x8 + x2 and x60 = x32 + x16 + x8 + x4.
  function automatic logic [15:0] bcd_to_sec(input logic [7:0] min_bcd,
                                             input logic [7:0] sec_bcd);
    logic [15:0] m;
    logic [15:0] s;
    m = ({12'd0, min_bcd[7:4]} << 3) + ({12'd0, min_bcd[7:4]} << 1) + {12'd0, min_bcd[3:0]};
    s = ({12'd0, sec_bcd[7:4]} << 3) + ({12'd0, sec_bcd[7:4]} << 1) + {12'd0, sec_bcd[3:0]};
    return (m << 5) + (m << 4) + (m << 3) + (m << 2) + s;
  endfunction

endpackage

// File: rtl/play_timer_if.sv
// Control and time-display bundle between the player UI and play_timer.
// PLAY_TIMER_LOAD_EN adds the preset-load signals.
interface play_timer_if #(
  parameter int unsigned SEC_WIDTH = 16
);
  logic                 run;
  logic                 clear;
`ifdef PLAY_TIMER_LOAD_EN
  logic                 load;
  logic [7:0]           load_min_bcd;
  logic [7:0]           load_sec_bcd;
`endif
  logic [SEC_WIDTH-1:0] Time;
  logic [7:0]           sec_bcd;
  logic [7:0]           min_bcd;
  logic                 sec_tick;
  logic                 ovf;

  modport master (
    output run, clear,
`ifdef PLAY_TIMER_LOAD_EN
    output load, load_min_bcd, load_sec_bcd,
`endif
    input  Time, sec_bcd, min_bcd, sec_tick, ovf
  );

  modport slave (
    input  run, clear,
`ifdef PLAY_TIMER_LOAD_EN
    input  load, load_min_bcd, load_sec_bcd,
`endif
    output Time, sec_bcd, min_bcd, sec_tick, ovf
  );
endinterface

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with clear, load and enable; wraps to 0 after MaxVal.
// carry is high when enabled at MaxVal, feeding the next digit's enable.
module bcd_digit_cnt
  import play_timer_pkg::*;
#(
  parameter bcd_digit_t MaxVal = DIGIT_MAX
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       en,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      digit_q <= '0;
    end else if (clr) begin
      digit_q <= '0;
    end else if (ld) begin
      digit_q <= ld_val;
    end else if (en) begin
      digit_q <= (digit_q == MaxVal) ? '0 : digit_q + 4'd1;
    end
  end

  assign digit = digit_q;
  assign carry = en && (digit_q == MaxVal);

endmodule

// File: rtl/play_timer.sv
// Playback elapsed-time counter: prescaler, saturating binary seconds, BCD mm:ss.
// Define PLAY_TIMER_LOAD_EN to add the mm:ss preset-load path.
module play_timer
  import play_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned SEC_WIDTH   = 16,
  parameter int unsigned MAX_MINUTES = 99
) (
  input logic          CLK,
  input logic          RST,
  play_timer_if.slave  bus
);

  localparam int unsigned        PreW       = $clog2(CLK_FREQ_HZ);
  localparam logic [PreW-1:0]    PreMax     = PreW'(CLK_FREQ_HZ - 1);
  localparam logic [7:0]         MaxMinBcd  = 8'(((MAX_MINUTES / 10) << 4) | (MAX_MINUTES % 10));

  logic [PreW-1:0]      pre_q;
  logic [SEC_WIDTH-1:0] time_q;
  logic                 tick_q;
  logic                 ovf_q;

  logic                 load;
  logic [7:0]           ld_min;
  logic [7:0]           ld_sec;
  logic [SEC_WIDTH-1:0] ld_time;

`ifdef PLAY_TIMER_LOAD_EN
  logic sec_ok;
  logic min_ok;

  assign load   = bus.load;
  assign sec_ok = (bus.load_sec_bcd[7:4] <= SEC_TENS_MAX) && (bus.load_sec_bcd[3:0] <= DIGIT_MAX);
  assign min_ok = (bus.load_min_bcd[7:4] <= DIGIT_MAX) && (bus.load_min_bcd[3:0] <= DIGIT_MAX) &&
                  (bus.load_min_bcd <= MaxMinBcd);
  assign ld_sec  = sec_ok ? bus.load_sec_bcd : 8'h59;
  assign ld_min  = min_ok ? bus.load_min_bcd : MaxMinBcd;
  assign ld_time = SEC_WIDTH'(bcd_to_sec(ld_min, ld_sec));
`else
  assign load    = 1'b0;
  assign ld_min  = '0;
  assign ld_sec  = '0;
  assign ld_time = '0;
`endif

  bcd_digit_t sec_lo, sec_hi, min_lo, min_hi;
  logic       c_sec_lo, c_sec_hi, c_min_lo, c_min_hi;
  logic       evt;
  logic       disp_sat;
  logic       time_sat;

  assign evt      = bus.run && (pre_q == PreMax);
  assign disp_sat = ({min_hi, min_lo} == MaxMinBcd) && ({sec_hi, sec_lo} == 8'h59);
  assign time_sat = &time_q;

  // Saturation gate: once the display shows MAX:59 the digit chain stops advancing.
  bcd_digit_cnt #(.MaxVal(DIGIT_MAX)) u_sec_lo (
    .CLK(CLK), .RST(RST), .clr(bus.clear), .ld(load), .ld_val(ld_sec[3:0]),
    .en(evt && !disp_sat), .digit(sec_lo), .carry(c_sec_lo)
  );

  bcd_digit_cnt #(.MaxVal(SEC_TENS_MAX)) u_sec_hi (
    .CLK(CLK), .RST(RST), .clr(bus.clear), .ld(load), .ld_val(ld_sec[7:4]),
    .en(c_sec_lo), .digit(sec_hi), .carry(c_sec_hi)
  );

  bcd_digit_cnt #(.MaxVal(DIGIT_MAX)) u_min_lo (
    .CLK(CLK), .RST(RST), .clr(bus.clear), .ld(load), .ld_val(ld_min[3:0]),
    .en(c_sec_hi), .digit(min_lo), .carry(c_min_lo)
  );

  bcd_digit_cnt #(.MaxVal(DIGIT_MAX)) u_min_hi (
    .CLK(CLK), .RST(RST), .clr(bus.clear), .ld(load), .ld_val(ld_min[7:4]),
    .en(c_min_lo), .digit(min_hi), .carry(c_min_hi)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pre_q  <= '0;
      time_q <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.clear) begin
      pre_q  <= '0;
      time_q <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load) begin
      pre_q  <= '0;
      time_q <= ld_time;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.run) begin
        if (pre_q == PreMax) begin
          pre_q  <= '0;
          tick_q <= 1'b1;
          if (!time_sat) begin
            time_q <= time_q + 1'b1;
          end
          if (time_sat || disp_sat) begin
            ovf_q <= 1'b1;
          end
        end else begin
          pre_q <= pre_q + 1'b1;
        end
      end
    end
  end

  assign bus.Time     = time_q;
  assign bus.sec_bcd  = {sec_hi, sec_lo};
  assign bus.min_bcd  = {min_hi, min_lo};
  assign bus.sec_tick = tick_q;
  assign bus.ovf      = ovf_q;

  // The top minute digit never wraps (saturation stops it first), so its carry is unused.
  logic unused_carry;
  assign unused_carry = c_min_hi;

endmodule

// File: tb/tb_play_timer.sv
// Scoreboarded random test of play_timer in three size configurations.
// Build with PLAY_TIMER_LOAD_EN defined to also exercise the preset-load path.
module tb_play_timer;

  localparam int F = 10;
  localparam int WC [3] = '{16, 8, 4};
  localparam int MC [3] = '{99, 1, 99};

  logic       CLK;
  logic       RST;
  logic       run;
  logic       clr;
  logic       ld;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;

  play_timer_if #(.SEC_WIDTH(16)) if0 ();
  play_timer_if #(.SEC_WIDTH(8))  if1 ();
  play_timer_if #(.SEC_WIDTH(4))  if2 ();

  assign if0.run = run;  assign if0.clear = clr;
  assign if1.run = run;  assign if1.clear = clr;
  assign if2.run = run;  assign if2.clear = clr;
`ifdef PLAY_TIMER_LOAD_EN
  assign if0.load = ld;  assign if0.load_min_bcd = ld_min;  assign if0.load_sec_bcd = ld_sec;
  assign if1.load = ld;  assign if1.load_min_bcd = ld_min;  assign if1.load_sec_bcd = ld_sec;
  assign if2.load = ld;  assign if2.load_min_bcd = ld_min;  assign if2.load_sec_bcd = ld_sec;
`endif

  play_timer #(.CLK_FREQ_HZ(F), .SEC_WIDTH(16), .MAX_MINUTES(99)) dut0 (
    .CLK(CLK), .RST(RST), .bus(if0)
  );
  play_timer #(.CLK_FREQ_HZ(F), .SEC_WIDTH(8), .MAX_MINUTES(1)) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1)
  );
  play_timer #(.CLK_FREQ_HZ(F), .SEC_WIDTH(4), .MAX_MINUTES(99)) dut2 (
    .CLK(CLK), .RST(RST), .bus(if2)
  );

  logic [15:0] d_time [3];
  logic [7:0]  d_sec  [3];
  logic [7:0]  d_min  [3];
  logic        d_tick [3];
  logic        d_ovf  [3];

  assign d_time[0] = 16'(if0.Time);  assign d_time[1] = 16'(if1.Time);  assign d_time[2] = 16'(if2.Time);
  assign d_sec[0]  = if0.sec_bcd;    assign d_sec[1]  = if1.sec_bcd;    assign d_sec[2]  = if2.sec_bcd;
  assign d_min[0]  = if0.min_bcd;    assign d_min[1]  = if1.min_bcd;    assign d_min[2]  = if2.min_bcd;
  assign d_tick[0] = if0.sec_tick;   assign d_tick[1] = if1.sec_tick;   assign d_tick[2] = if2.sec_tick;
  assign d_ovf[0]  = if0.ovf;        assign d_ovf[1]  = if1.ovf;        assign d_ovf[2]  = if2.ovf;

  // Reference model: elapsed seconds as plain integers, display derived by division.
  int m_pre  [3];
  int m_time [3];
  int m_disp [3];
  int m_ovf  [3];
  int m_tick [3];

  typedef struct {
    int inst;
    int cyc;
    int t;
    int s;
    int m;
    int o;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic model_zero(input int i);
    m_pre[i]  = 0;
    m_time[i] = 0;
    m_disp[i] = 0;
    m_ovf[i]  = 0;
  endtask

  task automatic step(input bit r, input bit c, input bit l, input logic [7:0] lm,
                      input logic [7:0] ls, input bit rn);
    int s, mm, hi, lo;
    exp_t e;
    RST = r; clr = c; ld = l; ld_min = lm; ld_sec = ls; run = rn;
    for (int i = 0; i < 3; i++) begin
      m_tick[i] = 0;
      if (!r || c) begin
        model_zero(i);
      end else if (l) begin
        hi = int'(ls[7:4]); lo = int'(ls[3:0]);
        s  = (hi > 5 || lo > 9) ? 59 : hi * 10 + lo;
        hi = int'(lm[7:4]); lo = int'(lm[3:0]);
        mm = (hi > 9 || lo > 9 || hi * 10 + lo > MC[i]) ? MC[i] : hi * 10 + lo;
        m_disp[i] = mm * 60 + s;
        m_time[i] = (mm * 60 + s) % (1 << WC[i]);
        m_ovf[i]  = 0;
        m_pre[i]  = 0;
      end else if (rn) begin
        if (m_pre[i] == F - 1) begin
          m_pre[i]  = 0;
          m_tick[i] = 1;
          if (m_time[i] == (1 << WC[i]) - 1) m_ovf[i] = 1;
          else m_time[i]++;
          if (m_disp[i] == MC[i] * 60 + 59) m_ovf[i] = 1;
          else m_disp[i]++;
          e.inst = i; e.cyc = cyc + 1; e.t = m_time[i];
          e.s = to_bcd(m_disp[i] % 60); e.m = to_bcd(m_disp[i] / 60); e.o = m_ovf[i];
          q.push_back(e);
        end else begin
          m_pre[i]++;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_n(input int n, input bit rn);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rn);
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_time%0d", nm, i), int'(d_time[i]), m_time[i]);
      chk($sformatf("%s_sec%0d", nm, i), int'(d_sec[i]), to_bcd(m_disp[i] % 60));
      chk($sformatf("%s_min%0d", nm, i), int'(d_min[i]), to_bcd(m_disp[i] / 60));
      chk($sformatf("%s_ovf%0d", nm, i), int'(d_ovf[i]), m_ovf[i]);
      chk($sformatf("%s_tick%0d", nm, i), int'(d_tick[i]), m_tick[i]);
    end
  endtask

  // Monitor: every presented sec_tick must match the oldest expected event for that DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
        if (d_tick[i]) begin
          if (q.size() > 0 && q[0].inst == i && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk($sformatf("ev_time%0d", i), int'(d_time[i]), e.t);
            chk($sformatf("ev_sec%0d", i), int'(d_sec[i]), e.s);
            chk($sformatf("ev_min%0d", i), int'(d_min[i]), e.m);
            chk($sformatf("ev_ovf%0d", i), int'(d_ovf[i]), e.o);
          end else begin
            chk($sformatf("unexpected_tick%0d", i), int'(d_tick[i]), 0);
          end
        end
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        chk($sformatf("missing_tick%0d", e.inst), int'(d_tick[e.inst]), 1);
      end
    end
  end

  initial begin
    bit r, c, l;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 3; i++) begin
      model_zero(i);
      m_tick[i] = 0;
    end
    RST = 1'b0; clr = 1'b0; ld = 1'b0; ld_min = 8'h00; ld_sec = 8'h00; run = 1'b0;

    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check_all("reset");

    run_n(100, 1'b1);
    check_all("run100");

    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    run_n(6, 1'b1);
    run_n(50, 1'b0);
    run_n(4, 1'b1);
    check_all("resume");

    // Clear coinciding with the prescaler terminal count.
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    run_n(9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    check_all("clr_term");

    run_n(605, 1'b1);
    check_all("carry_min");
    run_n(25, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check_all("rst_mid");

`ifdef PLAY_TIMER_LOAD_EN
    step(1'b1, 1'b0, 1'b1, 8'h02, 8'h75, 1'b1);
    check_all("load");
    run_n(15, 1'b1);
    check_all("after_load");
`endif

    for (int k = 0; k < 3000; k++) run_n(1, $urandom_range(0, 9) != 0);
    check_all("long_run");

    for (int k = 0; k < 2500; k++) begin
      r = $urandom_range(0, 299) != 0;
      c = $urandom_range(0, 149) == 0;
`ifdef PLAY_TIMER_LOAD_EN
      l = $urandom_range(0, 149) == 0;
`else
      l = 1'b0;
`endif
      step(r, c, l, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 6) != 0);
    end
    check_all("random");

    run_n(3, 1'b0);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/play_timer.md
Name: play_timer

Overview:
- Parametrised successor to the free-running one-second counter used by the MP3 player UI.
- Counts elapsed playback time from a prescaled system clock, with run/pause and clear control.
- Provides:
  - a binary total-seconds count;
  - BCD minutes:seconds for the seven-segment display;
  - a one-cycle seconds strobe for the display/track-progress logic.

Parameters:
- CLK_FREQ_HZ, 100000000, input clock cycles per counted second (≥2); prescaler terminal count = CLK_FREQ_HZ-1.
- SEC_WIDTH, 16, width of the binary total-seconds output.
- MAX_MINUTES, 99, highest displayed minute value (1..99); BCD display saturates at MAX_MINUTES:59.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous active-low reset; sampled on posedge CLK.
- run  input  1  1 = counting, 0 = paused (prescaler frozen, partial count kept).
- clear  input  1  synchronous clear of all time state; one-cycle pulse or level.
- Time  output  SEC_WIDTH  binary elapsed seconds, saturating.
- sec_bcd  output  8  BCD seconds, 00..59 ([7:4] tens, [3:0] units).
- min_bcd  output  8  BCD minutes, 00..MAX_MINUTES.
- sec_tick  output  1  one-cycle pulse in the cycle Time/BCD update.
- ovf  output  1  sticky: display saturated at MAX_MINUTES:59 or Time saturated.

Behaviour:
- Reset (RST=0 at posedge):
  - prescaler, Time, sec_bcd, min_bcd all 0;
  - sec_tick=0, ovf=0.
  - Reset overrides every other input.
- Priority in a cycle: reset > clear > load (optional) > count.
- clear=1:
  - same state as reset;
  - sec_tick forced 0;
  - clear during the terminal-count cycle suppresses that tick entirely.
- Prescaler, when run=1:
  - increments 0..CLK_FREQ_HZ-1;
  - at CLK_FREQ_HZ-1 it wraps to 0 and a second event occurs.
- Prescaler, when run=0:
  - holds its value;
  - no tick is generated.
  - On resume, the first tick arrives after the remaining CLK_FREQ_HZ-1-prescaler cycles.
- Second event:
  - registered outputs update at the same edge that wraps the prescaler;
  - sec_tick=1 for exactly the following cycle, aligned with the new Time/BCD values.
  - Latency from the first run=1 cycle after clear to the first sec_tick is exactly CLK_FREQ_HZ cycles.
- Time:
  - +1 per second event;
  - at all-ones it holds and sets ovf;
  - no wrap-around.
- BCD seconds: units 9→0 with carry to tens; 59→00 with carry to minutes.
- BCD minutes:
  - same digit scheme;
  - at MAX_MINUTES:59, a further second event holds MAX_MINUTES:59 and sets ovf.
  - Time continues counting independently until its own saturation.
- sec_tick still pulses on every second event, including while saturated.
- ovf clears only on reset or clear.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PLAY_TIMER_LOAD_EN.
- With the macro defined, extra inputs are added:
  - load (1 bit);
  - load_min_bcd (8 bits);
  - load_sec_bcd (8 bits).
- load=1 (when not in reset or clear):
  - sec_bcd and min_bcd take the load values;
  - Time takes min*60+sec (binary, computed with shift-add, truncated to SEC_WIDTH);
  - prescaler is set to 0;
  - ovf is cleared;
  - sec_tick is suppressed that cycle.
- Clamping of load values:
  - seconds >59 or any BCD digit >9 → clamp to 59;
  - minutes >MAX_MINUTES → clamp to MAX_MINUTES.
- Load has priority over a coincident second event.
- Without the macro, the ports are absent and behaviour is exactly as above.

Decomposition:
- Package play_timer_pkg holds:
  - BCD digit typedef (4 bits);
  - constants SEC_TENS_MAX=5 and DIGIT_MAX=9;
  - a function converting BCD minutes/seconds to binary seconds (used under PLAY_TIMER_LOAD_EN).
- Sub-module bcd_digit_cnt:
  - one BCD digit with enable, clear and configurable max value;
  - outputs the carry at its max;
  - instantiated four times (sec units, sec tens, min units, min tens), with a saturation gate in the top level.

Test Plan (CLK_FREQ_HZ=10 unless stated):
- Reset then run=1 for 100 cycles → first sec_tick at cycle 10, Time=10, sec_bcd=0x10, min_bcd=0x00, exactly 10 ticks.
- Run 6 cycles, run=0 for 50 cycles, run=1 → next sec_tick exactly 4 cycles after resume; no tick during pause.
- Run to 59 s, then one more second → sec_bcd 0x59→0x00, min_bcd 0x00→0x01, Time=60, single tick.
- MAX_MINUTES=1, run 120 s → display holds 01:59, ovf=1 after the 120th event, Time=120, ticks continue.
- SEC_WIDTH=4, run 16 s → Time holds 15, ovf=1; then clear → all zero, ovf=0, next tick after 10 cycles.
- clear asserted in the terminal-count cycle → no sec_tick, Time=0. RST=0 mid-count → all outputs 0 at the next edge. With PLAY_TIMER_LOAD_EN: load 0x02:0x75 → 02:59, Time=179.
